// File: rtl/corner_collector_pkg.sv
// Shared FAST parameter header: coordinate width, output word layout and counter widths.
// Producer and consumers import this so they agree on the word format.
package corner_collector_pkg;

    localparam int COORD_WIDTH_DEFAULT = 10;
    localparam int DROP_CNT_WIDTH      = 16;
    localparam int FRAME_CNT_WIDTH     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } collector_state_t;

    // Output word is {flag, payload}; the flag sits in the MSB (bit 20 for 10-bit coordinates).
    function automatic int wordWidth(input int coordWidth);
        return 2 * coordWidth + 1;
    endfunction

    function automatic int markerBit(input int coordWidth);
        return 2 * coordWidth;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flop-based storage, so the head word is always read from a register.
// Reports full, empty and the number of free entries.
module sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full       = (r_count == CW'(DEPTH));
    assign empty      = (r_count == '0);
    assign free_count = CW'(DEPTH) - r_count;
    assign rd_data    = r_mem[r_rdPtr];
    assign w_push     = wr_en && !full;
    assign w_pop      = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= wr_data;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/corner_collector.sv
// Packs FAST corners into a FIFO stream and closes each frame with a marker word
// carrying that frame's accepted-corner count.
module corner_collector
    import corner_collector_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int COORD_WIDTH = COORD_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic                         iscorner,
    input  logic [COORD_WIDTH-1:0]       x_coord,
    input  logic [COORD_WIDTH-1:0]       y_coord,
    input  logic                         frame_end,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [2*COORD_WIDTH:0]       m_data,
    output logic                         overflow,
    output logic [DROP_CNT_WIDTH-1:0]    drop_count,
    output logic [FRAME_CNT_WIDTH-1:0]   frame_count
);

    localparam int WORD_W = wordWidth(COORD_WIDTH);
    localparam int CNT_W  = markerBit(COORD_WIDTH);
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    collector_state_t     r_state;
    collector_state_t     w_stateNext;
    logic [CNT_W-1:0]     r_frameCorners;
    logic [DROP_CNT_WIDTH-1:0]  r_dropCount;
    logic [FRAME_CNT_WIDTH-1:0] r_frameCount;
    logic                 r_overflow;

    logic                 w_corner;
    logic                 w_frameEnd;
    logic                 w_cornerWrite;
    logic                 w_markerWrite;
    logic                 w_write;
    logic [WORD_W-1:0]    w_wrData;
    logic                 w_full;
    logic                 w_empty;
    logic [FREE_W-1:0]    w_freeCount;

    assign w_corner   = ce && iscorner;
    assign w_frameEnd = ce && frame_end;

    // Corners need two free slots so a later marker always has room; while a marker
    // is pending every corner is dropped.
    assign w_cornerWrite = w_corner && (w_freeCount >= FREE_W'(2)) && (r_state == ST_IDLE);
    assign w_markerWrite = (r_state == ST_PEND) && !w_full && !w_cornerWrite;
    assign w_write       = w_cornerWrite || w_markerWrite;
    assign w_wrData      = w_cornerWrite ? {1'b0, x_coord, y_coord} : {1'b1, r_frameCorners};

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: if (w_frameEnd) w_stateNext = ST_PEND;
            ST_PEND: if (w_markerWrite && !w_frameEnd) w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_frameCorners <= '0;
            r_dropCount    <= '0;
            r_frameCount   <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_markerWrite) begin
                r_frameCorners <= '0;
                r_frameCount   <= r_frameCount + FRAME_CNT_WIDTH'(1);
            end else if (w_cornerWrite && (r_frameCorners != '1)) begin
                r_frameCorners <= r_frameCorners + CNT_W'(1);
            end
            if (w_corner && !w_cornerWrite) begin
                r_overflow <= 1'b1;
                if (r_dropCount != '1) begin
                    r_dropCount <= r_dropCount + DROP_CNT_WIDTH'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (w_write),
        .wr_data    (w_wrData),
        .rd_en      (m_ready),
        .rd_data    (m_data),
        .full       (w_full),
        .empty      (w_empty),
        .free_count (w_freeCount)
    );

    assign m_valid     = !w_empty;
    assign overflow    = r_overflow;
    assign drop_count  = r_dropCount;
    assign frame_count = r_frameCount;

endmodule

// File: doc/corner_collector.md
CORNER_COLLECTOR -- requirements
Module: corner_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, number of 21-bit entries in the output buffer (power of two, at least 4).
REQ-002 SHALL have parameter COORD_WIDTH, default 10, width of x and y coordinates.
REQ-003 SHALL have input clk, 1 bit; it is the single clock, and all state is on its rising edge.
REQ-004 SHALL have input rst, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have input ce, 1 bit; it qualifies iscorner, x_coord, y_coord and frame_end.
REQ-006 SHALL have input iscorner, 1 bit; it is the corner strobe from the FAST/NMS pipeline.
REQ-007 SHALL have inputs x_coord and y_coord, COORD_WIDTH bits each; they give the corner position.
REQ-008 SHALL have input frame_end, 1 bit; it is a one-cycle last-pixel-of-frame strobe.
REQ-009 SHALL have output m_valid, 1 bit; it means the output word is valid.
REQ-010 SHALL have input m_ready, 1 bit; it is the downstream accept signal.
REQ-011 SHALL have output m_data, 2*COORD_WIDTH+1 bits; it carries the output word.
REQ-012 SHALL have output overflow, 1 bit; it is a sticky flag meaning at least one corner was dropped.
REQ-013 SHALL have output drop_count, 16 bits; it counts dropped corners and saturates.
REQ-014 SHALL have output frame_count, 16 bits; it counts emitted end-of-frame markers and wraps.

Function
REQ-015 SHALL treat a cycle with ce=1 and iscorner=1 as a corner event, and ignore iscorner, coordinates and frame_end while ce=0.
REQ-016 SHALL encode a corner word as m_data[20]=0, m_data[19:10]=x, m_data[9:0]=y.
REQ-017 SHALL encode a marker word as m_data[20]=1, m_data[19:0]=the frame's accepted-corner count, saturating at 20'hFFFFF.
REQ-018 SHALL write a corner only when the FIFO has at least 2 free entries (measured before the same-cycle read) and no marker is pending; otherwise it SHALL drop the corner, set overflow and increment drop_count.
REQ-019 SHALL set a marker_pending state on a frame_end event.
REQ-020 SHALL write the marker word in the first cycle that has marker_pending set, at least 1 free entry, and no corner write in that cycle.
REQ-021 SHALL clear marker_pending, reset the frame corner count to 0 and increment frame_count when the marker is written.
REQ-022 SHALL, when iscorner and frame_end occur in the same ce cycle, write the corner that cycle (if room), include it in the count, and write the marker no earlier than the next cycle.
REQ-023 SHALL, on a frame_end event while a marker is already pending, merge the two events: only one marker is written, and the count is not reset between them.
REQ-024 SHALL make corners arriving while marker_pending=1 count as drops, so the marker is never lost.
REQ-025 SHALL use a two-state FSM, IDLE and PEND. IDLE goes to PEND on frame_end. PEND goes to IDLE when the marker is written. In PEND with a marker write and a new frame_end in the same cycle, the FSM stays in PEND.
REQ-026 SHALL behave as a registered FIFO: a word written in cycle N to an empty FIFO appears with m_valid=1 in cycle N+1.
REQ-027 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-028 SHALL pop a word when m_valid=1 and m_ready=1, and SHALL support a simultaneous write and read in one cycle with occupancy unchanged.
REQ-029 SHALL never deassert m_valid without a handshake.

Reset
REQ-030 SHALL, on rst=1, clear immediately and regardless of clk: m_valid=0, m_data=0, overflow=0, drop_count=0, frame_count=0, FIFO empty, frame count 0, FSM in IDLE.
REQ-031 SHALL discard FIFO contents and any pending marker when rst is asserted mid-frame, and SHALL emit no marker for that partial frame.

Structure
REQ-032 SHALL place COORD_WIDTH, the m_data layout (bit 20 = marker flag) and the counter widths in the shared FAST parameter header, so the producer and consumers agree.
REQ-033 SHALL instantiate one sub-module, sync_fifo (parameterised width and depth, registered output, full/empty/free-count outputs), with the FSM and counters in corner_collector.

Verification
REQ-034 SHALL cover single corner: ce=1, iscorner=1, x=5, y=7 with m_ready=1 -> m_valid=1 one cycle later with m_data={1'b0,10'd5,10'd7}.
REQ-035 SHALL cover a normal frame: 3 corners then frame_end, m_ready=1 -> 3 corner words, then marker m_data=21'h100003, then frame_count=1.
REQ-036 SHALL cover backpressure: FIFO_DEPTH=4, m_ready=0, 5 corners then frame_end -> 3 accepted, drop_count=2, overflow=1; then m_ready=1 -> 3 corners, then marker with count 3.
REQ-037 SHALL cover simultaneous events: iscorner=1 and frame_end=1 in the same ce cycle -> corner word, then marker with count 1; the next frame's count starts at 0.
REQ-038 SHALL cover ce gating: iscorner=1 and frame_end=1 with ce=0 -> no writes and no state change.
REQ-039 SHALL cover reset mid-frame: 2 corners queued, then rst pulse -> m_valid=0 and all counters 0; a later frame_end gives a marker with count 0.
